iir_dac_serializer: RTL and testbench

Downstream output stage of the first-order IIR filter. It takes the filter's 32-bit sign-magnitude Q15.16 result on a sample strobe and quantizes it to a 12-bit offset-binary DAC code, with saturation. It then shifts a 16-bit command frame to an external SPI DAC (MCP4921-style) and pulses LDAC to latch the code. It reports busy, saturation and dropped-sample (overrun) status.

---
 rtl/iir_dac_pkg.sv | 6 +
 rtl/iir_dac_quantizer.sv | 34 +++
 rtl/iir_dac_serializer.sv | 107 ++++++++++
 tb/tb_iir_dac_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/iir_dac_pkg.sv
// iir_dac_pkg: shared state encoding and fixed-point constants for the IIR DAC output stage.
package iir_dac_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, LATCH} state_t;
    localparam int FRAC_BITS = 16;
    localparam logic [11:0] MIDSCALE = 12'h800;
endpackage

// File: rtl/iir_dac_quantizer.sv
// iir_dac_quantizer: sign-magnitude Q15.16 to offset-binary DAC code with saturation.
// Define IIR_DAC_ROUND_EN to round half-up instead of truncating.
module iir_dac_quantizer
    import iir_dac_pkg::*;
#(
    parameter int DAC_BITS = 12
) (
    input  logic [31:0]         y_i,
    output logic [DAC_BITS-1:0] code_o,
    output logic                sat_o
);
    localparam int SH = FRAC_BITS - (DAC_BITS - 1);
    localparam logic [31:0] MAXP = (32'd1 << (DAC_BITS - 1)) - 32'd1;
    localparam logic [31:0] MAXN = 32'd1 << (DAC_BITS - 1);
    localparam logic [DAC_BITS-1:0] MID = DAC_BITS'(MAXN);
    logic [31:0]         w_mag;
    logic [31:0]         w_m;
    logic                w_pos_sat;
    logic                w_neg_sat;
    logic [DAC_BITS-1:0] w_lim;
    assign w_mag = {1'b0, y_i[30:0]};
`ifdef IIR_DAC_ROUND_EN
    assign w_m = (w_mag + (32'd1 << (SH - 1))) >> SH;
`else
    assign w_m = w_mag >> SH;
`endif
    assign w_pos_sat = w_m > MAXP;
    assign w_neg_sat = w_m > MAXN;
    // Negative side may reach full midscale so that -1.0 lands exactly on code 0.
    assign w_lim  = y_i[31] ? (w_neg_sat ? DAC_BITS'(MAXN) : w_m[DAC_BITS-1:0])
                            : (w_pos_sat ? DAC_BITS'(MAXP) : w_m[DAC_BITS-1:0]);
    assign code_o = y_i[31] ? MID - w_lim : MID + w_lim;
    assign sat_o  = y_i[31] ? w_neg_sat : w_pos_sat;
endmodule

// File: rtl/iir_dac_serializer.sv
// iir_dac_serializer: quantizes IIR samples and shifts them to an MCP4921-style SPI DAC with LDAC latch.
// Optional rounding in the quantizer is enabled by defining IIR_DAC_ROUND_EN.
module iir_dac_serializer
    import iir_dac_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int DAC_BITS   = 12,
    parameter int FRAME_BITS = 16,
    parameter logic [FRAME_BITS-DAC_BITS-1:0] CFG_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick_i,
    input  logic [31:0] y_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic        sat_o,
    output logic        overrun_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        cs_n_o,
    output logic        ldac_n_o
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int EW = $clog2(2 * FRAME_BITS);
    state_t                r_state;
    state_t                w_next;
    logic [DW-1:0]         r_div;
    logic [EW-1:0]         r_edge;
    logic [FRAME_BITS-1:0] r_sreg;
    logic                  r_sat, r_overrun, r_sclk, r_mosi, r_cs_n, r_ldac_n;
    logic [DAC_BITS-1:0]   w_code;
    logic                  w_sat, w_tc, w_last, w_accept;
    logic [FRAME_BITS-1:0] w_frame;

    iir_dac_quantizer #(.DAC_BITS(DAC_BITS)) u_quant (
        .y_i    (y_i),
        .code_o (w_code),
        .sat_o  (w_sat)
    );

    assign w_frame  = {CFG_BITS, w_code};
    assign w_tc     = r_div == DW'(CLK_DIV - 1);
    assign w_last   = w_tc && r_edge == EW'(2 * FRAME_BITS - 1);
    assign w_accept = r_state == IDLE && sample_tick_i;

    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = SHIFT;
        else if (r_state == SHIFT && w_last) w_next = HOLD;
        else if (r_state == HOLD && w_tc) w_next = LATCH;
        else if (r_state == LATCH && w_tc) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_edge    <= '0;
            r_sreg    <= '0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_ldac_n  <= 1'b1;
        end else begin
            r_div <= (r_state == IDLE || w_tc) ? '0 : r_div + DW'(1);
            if (sample_tick_i && r_state != IDLE) r_overrun <= 1'b1;
            else if (clear_i) r_overrun <= 1'b0;
            if (w_accept) begin
                r_sreg <= w_frame;
                r_sat  <= w_sat;
                r_mosi <= w_frame[FRAME_BITS-1];
                r_cs_n <= 1'b0;
                r_edge <= '0;
            end
            if (r_state == SHIFT && w_tc) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + EW'(1);
                // Data changes only on the falling edge so it is stable at the DAC's rising-edge sample.
                if (r_sclk) begin
                    r_sreg <= r_sreg << 1;
                    r_mosi <= r_sreg[FRAME_BITS-2];
                end
                if (w_last) begin
                    r_cs_n <= 1'b1;
                    r_mosi <= 1'b0;
                end
            end
            if (r_state == HOLD && w_tc) r_ldac_n <= 1'b0;
            if (r_state == LATCH && w_tc) r_ldac_n <= 1'b1;
        end
    end

    assign busy_o    = r_state != IDLE;
    assign sat_o     = r_sat;
    assign overrun_o = r_overrun;
    assign sclk_o    = r_sclk;
    assign mosi_o    = r_mosi;
    assign cs_n_o    = r_cs_n;
    assign ldac_n_o  = r_ldac_n;
endmodule

// File: tb/tb_iir_dac_serializer.sv
// tb_iir_dac_serializer: directed scoreboard bench for the IIR DAC serializer and its quantizer.
module tb_iir_dac_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick_i = 1'b0;
    logic [31:0] y_i = '0;
    logic        clear_i = 1'b0;
    logic        busy_o, sat_o, overrun_o, sclk_o, mosi_o, cs_n_o, ldac_n_o;
    logic [31:0] y_q = '0;
    logic [11:0] code_q;
    logic        sat_q;

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    iir_dac_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick_i (sample_tick_i),
        .y_i           (y_i),
        .clear_i       (clear_i),
        .busy_o        (busy_o),
        .sat_o         (sat_o),
        .overrun_o     (overrun_o),
        .sclk_o        (sclk_o),
        .mosi_o        (mosi_o),
        .cs_n_o        (cs_n_o),
        .ldac_n_o      (ldac_n_o)
    );

    iir_dac_quantizer u_q (
        .y_i    (y_q),
        .code_o (code_q),
        .sat_o  (sat_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: signed value around midscale, then clip to the 12-bit range.
    function automatic logic [16:0] model(input logic [31:0] y);
        longint v;
        longint c;
`ifdef IIR_DAC_ROUND_EN
        v = (longint'(y[30:0]) + 16) / 32;
`else
        v = longint'(y[30:0]) / 32;
`endif
        if (y[31]) v = -v;
        c = v + 2048;
        if (c > 4095) return {1'b1, 4'h3, 12'hFFF};
        if (c < 0) return {1'b1, 4'h3, 12'h000};
        return {1'b0, 4'h3, 12'(c)};
    endfunction

    logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_busy = 1'b0;
    int          nbits = 0, busy_cnt = 0, ldac_cnt = 0, cs2ldac = 0, ldac_pulses = 0;
    logic [15:0] cap = '0;
    logic [16:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits = 0; busy_cnt = 0; ldac_cnt = 0;
            p_sclk = 1'b0; p_cs = 1'b1; p_ldac = 1'b1; p_busy = 1'b0;
        end else begin
            if (!cs_n_o && sclk_o && !p_sclk) begin
                cap = {cap[14:0], mosi_o};
                nbits++;
            end
            if (cs_n_o && !p_cs) begin
                if (exp_q.size() == 0) chk("unexpected_frame", 32'(cap), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("frame_bits", nbits, 16);
                    chk("frame", 32'(cap), 32'(e[15:0]));
                    chk("sat", 32'(sat_o), 32'(e[16]));
                end
                nbits = 0;
                cs2ldac = 0;
            end else cs2ldac++;
            if (!ldac_n_o && p_ldac) begin
                chk("cs_to_ldac", cs2ldac, 2);
                ldac_pulses++;
            end
            if (!ldac_n_o) ldac_cnt++;
            if (ldac_n_o && !p_ldac) begin
                chk("ldac_width", ldac_cnt, 2);
                ldac_cnt = 0;
            end
            if (busy_o) busy_cnt++;
            if (!busy_o && p_busy) begin
                chk("busy_len", busy_cnt, 68);
                busy_cnt = 0;
            end
            p_sclk = sclk_o; p_cs = cs_n_o; p_ldac = ldac_n_o; p_busy = busy_o;
        end
    end

    task automatic send(input logic [31:0] y, input logic push, input logic [16:0] ex);
        y_i = y;
        sample_tick_i = 1'b1;
        if (push) exp_q.push_back(ex);
        @(negedge clk);
        sample_tick_i = 1'b0;
        y_i = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(busy_o), 32'd0);
    endtask

    task automatic drop(input logic clr);
        y_i = $urandom;
        sample_tick_i = 1'b1;
        clear_i = clr;
        @(negedge clk);
        sample_tick_i = 1'b0;
        clear_i = 1'b0;
    endtask

    logic [31:0] qy[11] = '{32'h0000_0000, 32'h0000_8000, 32'h8001_0000, 32'h8000_0000,
                            32'h0003_4000, 32'h8005_0000, 32'h0000_FFE0, 32'h0001_0000,
                            32'h8001_0020, 32'h7FFF_FFFF, 32'h0000_000F};
    logic [12:0] qe[11] = '{13'h0800, 13'h0C00, 13'h0000, 13'h0800,
                            13'h1FFF, 13'h1000, 13'h0FFF, 13'h1FFF,
                            13'h1000, 13'h1FFF, 13'h0800};

    initial begin
        for (int i = 0; i < 11; i++) begin
            y_q = qy[i];
            #1;
            chk("quant_code", 32'(code_q), 32'(qe[i][11:0]));
            chk("quant_sat", 32'(sat_q), 32'(qe[i][12]));
        end
        y_q = 32'h0000_0010;
        #1;
`ifdef IIR_DAC_ROUND_EN
        chk("quant_round", 32'(code_q), 32'h801);
`else
        chk("quant_round", 32'(code_q), 32'h800);
`endif
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_sat", 32'(sat_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        chk("rst_sclk", 32'(sclk_o), 0);
        chk("rst_mosi", 32'(mosi_o), 0);
        chk("rst_cs_n", 32'(cs_n_o), 1);
        chk("rst_ldac_n", 32'(ldac_n_o), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h0000_0000, 1, 17'h0_3800); wait_idle();
        send(32'h0000_8000, 1, 17'h0_3C00); wait_idle();
        send(32'h8001_0000, 1, 17'h0_3000); wait_idle();
        send(32'h8000_0000, 1, 17'h0_3800); wait_idle();
        send(32'h0003_4000, 1, 17'h1_3FFF); wait_idle();
        send(32'h8005_0000, 1, 17'h1_3000); wait_idle();
`ifdef IIR_DAC_ROUND_EN
        send(32'h0000_0010, 1, 17'h0_3801); wait_idle();
`else
        send(32'h0000_0010, 1, 17'h0_3800); wait_idle();
`endif
        for (int i = 0; i < 3; i++) begin
            logic [31:0] r;
            r = {$urandom_range(1, 0) == 1, 11'd0, 20'($urandom)};
            send(r, 1, model(r));
            wait_idle();
        end

        send(32'h0000_4000, 1, 17'h0_3A00);
        repeat (8) @(negedge clk);
        chk("overrun_pre", 32'(overrun_o), 0);
        drop(1'b0);
        chk("overrun_set", 32'(overrun_o), 1);
        wait_idle();
        send(32'h8000_4000, 1, 17'h0_3600);
        repeat (5) @(negedge clk);
        drop(1'b1);
        chk("overrun_set_wins", 32'(overrun_o), 1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("overrun_clear", 32'(overrun_o), 0);
        wait_idle();

        send(32'h0000_2000, 1, 17'h0_3900);
        wait_idle();
        send(32'h8000_2000, 1, 17'h0_3700);
        chk("b2b_accept", 32'(busy_o), 1);
        chk("b2b_no_overrun", 32'(overrun_o), 0);
        wait_idle();

        send(32'h0000_6000, 0, '0);
        repeat (20) @(negedge clk);
        begin
            int lp;
            lp = ldac_pulses;
            #1 rst_n = 1'b0;
            #1;
            chk("arst_cs_n", 32'(cs_n_o), 1);
            chk("arst_sclk", 32'(sclk_o), 0);
            chk("arst_busy", 32'(busy_o), 0);
            chk("arst_ldac_n", 32'(ldac_n_o), 1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (80) @(negedge clk);
            chk("arst_no_ldac", ldac_pulses, lp);
        end
        send(32'h0000_6000, 1, 17'h0_3B00);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
